// File: rtl/spi_pkg.sv
// Shared constants for the SPI master: register map, CTRL/STATUS bit positions, FSM states.
package spi_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_TXDATA = 2'd2;
    localparam logic [1:0] ADDR_RXDATA = 2'd3;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_CPOL    = 1;
    localparam int unsigned CTRL_CPHA    = 2;
    localparam int unsigned CTRL_LSB     = 3;
    localparam int unsigned CTRL_IRQ_EN  = 4;
    localparam int unsigned CTRL_CS_LSB  = 8;
    localparam int unsigned CTRL_DIV_LSB = 16;

    localparam int unsigned ST_BUSY       = 0;
    localparam int unsigned ST_TX_FULL    = 1;
    localparam int unsigned ST_TX_EMPTY   = 2;
    localparam int unsigned ST_RX_FULL    = 3;
    localparam int unsigned ST_RX_EMPTY   = 4;
    localparam int unsigned ST_TX_DROP    = 5;
    localparam int unsigned ST_RX_OVF     = 6;
    localparam int unsigned ST_TX_CNT_LSB = 8;
    localparam int unsigned ST_RX_CNT_LSB = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO; a pop in the same cycle makes room for a push into a full FIFO.
module spi_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wd,
    input  logic          pop,
    output logic [W-1:0]  rd,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd      = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_master_fifo.sv
// SPI master with CPU register map, TX/RX FIFOs, clock divider, CPOL/CPHA modes and chip selects.
module spi_master_fifo
    import spi_pkg::*;
#(
    parameter int unsigned W_DATA     = 32,
    parameter int unsigned W_FRAME    = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned N_CS       = 2,
    parameter int unsigned DIV_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cpu_addr,
    input  logic [W_DATA-1:0] cpu_wd,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [W_DATA-1:0] cpu_rd,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [N_CS-1:0]   spi_cs_n,
    output logic              irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EW = $clog2(2 * W_FRAME + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * W_FRAME - 1);

    logic               ctrl_en, ctrl_cpol, ctrl_cpha, ctrl_lsb, ctrl_irq_en;
    logic [7:0]         ctrl_cs;
    logic [DIV_W-1:0]   ctrl_div;
    logic               tx_drop, rx_ovf;

    logic [1:0]         state, state_nxt;
    logic [DIV_W-1:0]   div_cnt, div_l;
    logic [EW-1:0]      edge_cnt;
    logic               cpha_l, lsb_l;
    logic [W_FRAME-1:0] tx_sh, rx_sh, rx_nxt;

    logic               tx_push, tx_pop, tx_full, tx_empty;
    logic [W_FRAME-1:0] tx_head;
    logic [CW-1:0]      tx_count;
    logic               rx_push, rx_pop, rx_full, rx_empty;
    logic [W_FRAME-1:0] rx_head;
    logic [CW-1:0]      rx_count;

    logic               wr_ctrl, wr_status;
    logic               tick, last_edge, sample_edge, can_start, start;
    logic               unused_wd;

    function automatic logic first_out(input logic [W_FRAME-1:0] d, input logic lsb);
        return lsb ? d[0] : d[W_FRAME-1];
    endfunction

    function automatic logic [W_FRAME-1:0] shift_out(input logic [W_FRAME-1:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    function automatic logic [W_FRAME-1:0] shift_in(input logic [W_FRAME-1:0] d, input logic lsb,
                                                    input logic b);
        return lsb ? ((d >> 1) | (W_FRAME'(b) << (W_FRAME - 1))) : ((d << 1) | W_FRAME'(b));
    endfunction

    // Out-of-range selects leave every line deasserted.
    function automatic logic [N_CS-1:0] cs_decode(input logic [7:0] sel);
        logic [N_CS-1:0] d;
        for (int unsigned i = 0; i < N_CS; i++) begin
            d[i] = (sel != 8'(i));
        end
        return d;
    endfunction

    assign unused_wd   = ^cpu_wd;
    assign wr_ctrl     = cpu_we & (cpu_addr == ADDR_CTRL);
    assign wr_status   = cpu_we & (cpu_addr == ADDR_STATUS);
    assign tx_push     = cpu_we & (cpu_addr == ADDR_TXDATA);
    assign rx_pop      = cpu_re & (cpu_addr == ADDR_RXDATA);

    assign tick        = (div_cnt == div_l);
    assign last_edge   = (edge_cnt == LAST_EDGE);
    assign can_start   = ctrl_en & ~tx_empty;
    assign sample_edge = (state == S_SHIFT) & tick & (edge_cnt[0] == cpha_l);
    assign rx_nxt      = sample_edge ? shift_in(rx_sh, lsb_l, spi_miso) : rx_sh;

    spi_fifo #(.W(W_FRAME), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wd    (cpu_wd[W_FRAME-1:0]),
        .pop   (tx_pop),
        .rd    (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    spi_fifo #(.W(W_FRAME), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wd    (rx_nxt),
        .pop   (rx_pop),
        .rd    (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Register map: CTRL fields and sticky flags (set wins over a same-cycle W1C).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en     <= 1'b0;
            ctrl_cpol   <= 1'b0;
            ctrl_cpha   <= 1'b0;
            ctrl_lsb    <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_cs     <= '0;
            ctrl_div    <= '0;
            tx_drop     <= 1'b0;
            rx_ovf      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= cpu_wd[CTRL_EN];
                ctrl_cpol   <= cpu_wd[CTRL_CPOL];
                ctrl_cpha   <= cpu_wd[CTRL_CPHA];
                ctrl_lsb    <= cpu_wd[CTRL_LSB];
                ctrl_irq_en <= cpu_wd[CTRL_IRQ_EN];
                ctrl_cs     <= cpu_wd[CTRL_CS_LSB +: 8];
                ctrl_div    <= cpu_wd[CTRL_DIV_LSB +: DIV_W];
            end
            if (tx_push & tx_full & ~tx_pop) begin
                tx_drop <= 1'b1;
            end else if (wr_status & cpu_wd[ST_TX_DROP]) begin
                tx_drop <= 1'b0;
            end
            if (rx_push & rx_full & ~rx_pop) begin
                rx_ovf <= 1'b1;
            end else if (wr_status & cpu_wd[ST_RX_OVF]) begin
                rx_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        cpu_rd = '0;
        case (cpu_addr)
            ADDR_CTRL: begin
                cpu_rd[CTRL_EN]                = ctrl_en;
                cpu_rd[CTRL_CPOL]              = ctrl_cpol;
                cpu_rd[CTRL_CPHA]              = ctrl_cpha;
                cpu_rd[CTRL_LSB]               = ctrl_lsb;
                cpu_rd[CTRL_IRQ_EN]            = ctrl_irq_en;
                cpu_rd[CTRL_CS_LSB +: 8]       = ctrl_cs;
                cpu_rd[CTRL_DIV_LSB +: DIV_W]  = ctrl_div;
            end
            ADDR_STATUS: begin
                cpu_rd[ST_BUSY]                = (state != S_IDLE);
                cpu_rd[ST_TX_FULL]             = tx_full;
                cpu_rd[ST_TX_EMPTY]            = tx_empty;
                cpu_rd[ST_RX_FULL]             = rx_full;
                cpu_rd[ST_RX_EMPTY]            = rx_empty;
                cpu_rd[ST_TX_DROP]             = tx_drop;
                cpu_rd[ST_RX_OVF]              = rx_ovf;
                cpu_rd[ST_TX_CNT_LSB +: 8]     = 8'(tx_count);
                cpu_rd[ST_RX_CNT_LSB +: 8]     = 8'(rx_count);
            end
            ADDR_RXDATA: begin
                if (!rx_empty) begin
                    cpu_rd = W_DATA'(rx_head);
                end
            end
            default: cpu_rd = '0;
        endcase
    end

    // Next-state logic; a frame starts from IDLE or directly from GAP for back-to-back transfers.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        case (state)
            S_IDLE: begin
                if (can_start) begin
                    state_nxt = S_SETUP;
                    start     = 1'b1;
                    tx_pop    = 1'b1;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (tick && last_edge) begin
                    state_nxt = S_GAP;
                    rx_push   = 1'b1;
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (can_start) begin
                        state_nxt = S_SHIFT;
                        start     = 1'b1;
                        tx_pop    = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Serial datapath: divider, edge counter, shifters and pin drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            div_l    <= '0;
            edge_cnt <= '0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= '1;
            irq      <= 1'b0;
        end else begin
            irq     <= ctrl_irq_en & ~rx_empty;
            div_cnt <= (state == S_IDLE || tick) ? '0 : div_cnt + 1'b1;
            if (state == S_IDLE) begin
                spi_sclk <= ctrl_cpol;
            end
            if (start) begin
                cpha_l   <= ctrl_cpha;
                lsb_l    <= ctrl_lsb;
                div_l    <= ctrl_div;
                edge_cnt <= '0;
                rx_sh    <= '0;
                spi_sclk <= ctrl_cpol;
                spi_cs_n <= cs_decode(ctrl_cs);
                if (!ctrl_cpha) begin
                    spi_mosi <= first_out(tx_head, ctrl_lsb);
                    tx_sh    <= shift_out(tx_head, ctrl_lsb);
                end else begin
                    tx_sh    <= tx_head;
                end
            end else if (state == S_SHIFT && tick) begin
                spi_sclk <= ~spi_sclk;
                edge_cnt <= edge_cnt + 1'b1;
                rx_sh    <= rx_nxt;
                if (!sample_edge && !last_edge) begin
                    spi_mosi <= first_out(tx_sh, lsb_l);
                    tx_sh    <= shift_out(tx_sh, lsb_l);
                end
            end else if (state == S_GAP && tick) begin
                spi_cs_n <= '1;
            end
        end
    end

endmodule
